// File: rtl/register_bank.sv
// Architectural register bank (AR, DR, PC, IR, R1-R7, AC) with a wired-OR shared bus,
// registered zero flag and a sticky bus-contention detector.
module register_bank #(
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RAR,
   input  logic              RDR,
   input  logic              RPC,
   input  logic              RIR,
   input  logic              RR1,
   input  logic              RR2,
   input  logic              RR3,
   input  logic              RR4,
   input  logic              RR5,
   input  logic              RR6,
   input  logic              RR7,
   input  logic              RAC,
   input  logic              WAR,
   input  logic              WDR,
   input  logic              WPC,
   input  logic              WIR,
   input  logic              WR1,
   input  logic              WR2,
   input  logic              WR3,
   input  logic              WR4,
   input  logic              WR5,
   input  logic              WR6,
   input  logic              WR7,
   input  logic              WAC,
   input  logic              RSTR1,
   input  logic              RSTR2,
   input  logic              RSTR3,
   input  logic              RSTR4,
   input  logic              RSTR5,
   input  logic              RSTR6,
   input  logic              RSTR7,
   input  logic              R2INC,
   input  logic              PCINC,
   input  logic              ALUOP,
   input  logic              INSREAD,
   input  logic              MEMREAD,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] imem_rdata,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [DATA_W-1:0] bus,
   output logic [DATA_W-1:0] pc_out,
   output logic [DATA_W-1:0] ar_out,
   output logic [DATA_W-1:0] dr_out,
   output logic [DATA_W-1:0] ir_out,
   output logic [DATA_W-1:0] ac_out,
   output logic [DATA_W-1:0] r1_out,
   output logic [DATA_W-1:0] r5_out,
   output logic              Z,
   output logic              bus_err
);

   localparam logic [DATA_W-1:0] one_val = DATA_W'(1);

   logic [DATA_W-1:0] ar_q, ar_d;
   logic [DATA_W-1:0] dr_q, dr_d;
   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] ac_q, ac_d;
   logic [DATA_W-1:0] r_q [1:7];
   logic [DATA_W-1:0] r_d [1:7];
   logic              z_q, z_d;
   logic              err_q, err_d;

   logic [7:1]        rd_r;
   logic [7:1]        wr_r;
   logic [7:1]        clr_r;
   logic [11:0]       sel;
   logic              multi_sel;

   assign rd_r  = {RR7, RR6, RR5, RR4, RR3, RR2, RR1};
   assign wr_r  = {WR7, WR6, WR5, WR4, WR3, WR2, WR1};
   assign clr_r = {RSTR7, RSTR6, RSTR5, RSTR4, RSTR3, RSTR2, RSTR1};
   assign sel   = {RAR, RDR, RPC, RIR, rd_r, RAC};

   // Clearing the lowest set bit leaves something only if two or more selects are high.
   assign multi_sel = |(sel & (sel - 12'd1));

   always_comb begin
      bus = '0;
      if (RAR) bus = bus | ar_q;
      if (RDR) bus = bus | dr_q;
      if (RPC) bus = bus | pc_q;
      if (RIR) bus = bus | ir_q;
      if (RAC) bus = bus | ac_q;
      for (int i = 1; i <= 7; i++) begin
         if (rd_r[i]) bus = bus | r_q[i];
      end
   end

   always_comb begin
      ar_d  = ar_q;
      dr_d  = dr_q;
      pc_d  = pc_q;
      ir_d  = ir_q;
      ac_d  = ac_q;
      z_d   = z_q;
      err_d = err_q | multi_sel;

      if (WAR) ar_d = bus;

      if (MEMREAD)  dr_d = dmem_rdata;
      else if (WDR) dr_d = bus;

      if (WPC)        pc_d = bus;
      else if (PCINC) pc_d = pc_q + one_val;

      if (INSREAD)  ir_d = imem_rdata;
      else if (WIR) ir_d = bus;

      if (ALUOP) begin
         ac_d = alu_result;
         z_d  = (alu_result == '0);
      end else if (WAC) begin
         ac_d = bus;
      end

      for (int i = 1; i <= 7; i++) begin
         r_d[i] = r_q[i];
         if (clr_r[i])     r_d[i] = '0;
         else if (wr_r[i]) r_d[i] = bus;
      end
      // Only R2 has an incrementer, below both clear and load.
      if (!RSTR2 && !WR2 && R2INC) r_d[2] = r_q[2] + one_val;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ar_q  <= '0;
         dr_q  <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         ac_q  <= '0;
         z_q   <= 1'b0;
         err_q <= 1'b0;
         for (int i = 1; i <= 7; i++) r_q[i] <= '0;
      end else begin
         ar_q  <= ar_d;
         dr_q  <= dr_d;
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         ac_q  <= ac_d;
         z_q   <= z_d;
         err_q <= err_d;
         for (int i = 1; i <= 7; i++) r_q[i] <= r_d[i];
      end
   end

   assign pc_out  = pc_q;
   assign ar_out  = ar_q;
   assign dr_out  = dr_q;
   assign ir_out  = ir_q;
   assign ac_out  = ac_q;
   assign r1_out  = r_q[1];
   assign r5_out  = r_q[5];
   assign Z       = z_q;
   assign bus_err = err_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: reset, transfers, strobe priority, wrap, Z flag,
// fetch/memory loads and bus contention.
module tb_register_bank;

   logic clk = 1'b0;
   logic rst_n;
   logic RAR, RDR, RPC, RIR, RR1, RR2, RR3, RR4, RR5, RR6, RR7, RAC;
   logic WAR, WDR, WPC, WIR, WR1, WR2, WR3, WR4, WR5, WR6, WR7, WAC;
   logic RSTR1, RSTR2, RSTR3, RSTR4, RSTR5, RSTR6, RSTR7;
   logic R2INC, PCINC, ALUOP, INSREAD, MEMREAD;
   logic [15:0] alu_result, imem_rdata, dmem_rdata;
   logic [15:0] bus, pc_out, ar_out, dr_out, ir_out, ac_out, r1_out, r5_out;
   logic Z, bus_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   register_bank #(.DATA_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .RAR(RAR), .RDR(RDR), .RPC(RPC), .RIR(RIR),
      .RR1(RR1), .RR2(RR2), .RR3(RR3), .RR4(RR4), .RR5(RR5), .RR6(RR6), .RR7(RR7),
      .RAC(RAC),
      .WAR(WAR), .WDR(WDR), .WPC(WPC), .WIR(WIR),
      .WR1(WR1), .WR2(WR2), .WR3(WR3), .WR4(WR4), .WR5(WR5), .WR6(WR6), .WR7(WR7),
      .WAC(WAC),
      .RSTR1(RSTR1), .RSTR2(RSTR2), .RSTR3(RSTR3), .RSTR4(RSTR4),
      .RSTR5(RSTR5), .RSTR6(RSTR6), .RSTR7(RSTR7),
      .R2INC(R2INC), .PCINC(PCINC), .ALUOP(ALUOP), .INSREAD(INSREAD), .MEMREAD(MEMREAD),
      .alu_result(alu_result), .imem_rdata(imem_rdata), .dmem_rdata(dmem_rdata),
      .bus(bus), .pc_out(pc_out), .ar_out(ar_out), .dr_out(dr_out), .ir_out(ir_out),
      .ac_out(ac_out), .r1_out(r1_out), .r5_out(r5_out), .Z(Z), .bus_err(bus_err)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic clr_strobes();
      {RAR, RDR, RPC, RIR, RR1, RR2, RR3, RR4, RR5, RR6, RR7, RAC} = '0;
      {WAR, WDR, WPC, WIR, WR1, WR2, WR3, WR4, WR5, WR6, WR7, WAC} = '0;
      {RSTR1, RSTR2, RSTR3, RSTR4, RSTR5, RSTR6, RSTR7} = '0;
      {R2INC, PCINC, ALUOP, INSREAD, MEMREAD} = '0;
   endtask

   // Strobes are held across the edge, then cleared 1ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
      clr_strobes();
   endtask

   task automatic load_ac(input logic [15:0] v);
      ALUOP = 1'b1;
      alu_result = v;
      tick();
   endtask

   initial begin
      rst_n = 1'b1;
      clr_strobes();
      alu_result = '0;
      imem_rdata = '0;
      dmem_rdata = '0;
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_pc", pc_out, 16'h0000);
      check_eq("rst_ar", ar_out, 16'h0000);
      check_eq("rst_dr", dr_out, 16'h0000);
      check_eq("rst_ir", ir_out, 16'h0000);
      check_eq("rst_ac", ac_out, 16'h0000);
      check_eq("rst_r1", r1_out, 16'h0000);
      check_eq("rst_z", {15'd0, Z}, 16'h0000);
      check_eq("rst_bus", bus, 16'h0000);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Transfer R1 -> R4
      load_ac(16'h1234);
      RAC = 1'b1; WR1 = 1'b1; tick();
      check_eq("r1_load", r1_out, 16'h1234);
      RR1 = 1'b1; WR4 = 1'b1; #1;
      check_eq("xfer_bus", bus, 16'h1234);
      tick();
      RR4 = 1'b1; #1;
      check_eq("r4_load", bus, 16'h1234);
      check_eq("xfer_err", {15'd0, bus_err}, 16'h0000);
      clr_strobes();
      RR1 = 1'b1; WR1 = 1'b1; tick();
      check_eq("r1_self", r1_out, 16'h1234);
      RSTR1 = 1'b1; WR1 = 1'b1; RAC = 1'b1; tick();
      check_eq("r1_clr_prio", r1_out, 16'h0000);
      RAC = 1'b1; WR5 = 1'b1; tick();
      check_eq("r5_load", r5_out, 16'h1234);

      // PC wrap and priority
      load_ac(16'hFFFF);
      RAC = 1'b1; WPC = 1'b1; tick();
      check_eq("pc_load", pc_out, 16'hFFFF);
      PCINC = 1'b1; tick();
      check_eq("pc_wrap", pc_out, 16'h0000);
      RAC = 1'b1; WPC = 1'b1; PCINC = 1'b1; tick();
      check_eq("pc_wr_prio", pc_out, 16'hFFFF);

      // R2 priority
      load_ac(16'h0007);
      RAC = 1'b1; WR2 = 1'b1; tick();
      load_ac(16'h00A0);
      RAC = 1'b1; WR2 = 1'b1; R2INC = 1'b1; tick();
      RR2 = 1'b1; #1;
      check_eq("r2_wr_prio", bus, 16'h00A0);
      clr_strobes();
      RAC = 1'b1; WR2 = 1'b1; R2INC = 1'b1; RSTR2 = 1'b1; tick();
      RR2 = 1'b1; #1;
      check_eq("r2_clr_prio", bus, 16'h0000);
      clr_strobes();
      R2INC = 1'b1; tick();
      RR2 = 1'b1; #1;
      check_eq("r2_inc", bus, 16'h0001);
      clr_strobes();

      // ALU / Z
      load_ac(16'h0005);
      RAC = 1'b1; WR6 = 1'b1; tick();
      load_ac(16'h0000);
      check_eq("alu0_ac", ac_out, 16'h0000);
      check_eq("alu0_z", {15'd0, Z}, 16'h0001);
      RR6 = 1'b1; WAC = 1'b1; tick();
      check_eq("wac_ac", ac_out, 16'h0005);
      check_eq("wac_z_hold", {15'd0, Z}, 16'h0001);
      load_ac(16'h0003);
      check_eq("alu3_ac", ac_out, 16'h0003);
      check_eq("alu3_z", {15'd0, Z}, 16'h0000);

      // Fetch
      load_ac(16'h0010);
      RAC = 1'b1; WPC = 1'b1; tick();
      imem_rdata = 16'hA512;
      INSREAD = 1'b1; PCINC = 1'b1; tick();
      check_eq("fetch_ir", ir_out, 16'hA512);
      check_eq("fetch_pc", pc_out, 16'h0011);
      imem_rdata = 16'h5A5A;
      INSREAD = 1'b1; WIR = 1'b1; RAC = 1'b1; tick();
      check_eq("ir_rd_prio", ir_out, 16'h5A5A);
      WIR = 1'b1; RAC = 1'b1; tick();
      check_eq("ir_wir", ir_out, 16'h0010);

      // Data memory / AR
      dmem_rdata = 16'hBEEF;
      MEMREAD = 1'b1; WDR = 1'b1; RAC = 1'b1; tick();
      check_eq("dr_rd_prio", dr_out, 16'hBEEF);
      WDR = 1'b1; RAC = 1'b1; tick();
      check_eq("dr_wdr", dr_out, 16'h0010);
      WAR = 1'b1; RAC = 1'b1; tick();
      check_eq("ar_war", ar_out, 16'h0010);

      // Contention
      load_ac(16'h00F0);
      RAC = 1'b1; WR3 = 1'b1; tick();
      load_ac(16'h0F00);
      RR3 = 1'b1; RAC = 1'b1; #1;
      check_eq("cont_bus", bus, 16'h0FF0);
      check_eq("cont_err_pre", {15'd0, bus_err}, 16'h0000);
      tick();
      check_eq("cont_err_set", {15'd0, bus_err}, 16'h0001);
      tick();
      check_eq("cont_err_sticky", {15'd0, bus_err}, 16'h0001);

      // Mid-cycle reset with strobes pending
      load_ac(16'h0000);
      check_eq("pre_rst_z", {15'd0, Z}, 16'h0001);
      PCINC = 1'b1; RAC = 1'b1; WR1 = 1'b1;
      rst_n = 1'b0; #1;
      check_eq("mrst_pc", pc_out, 16'h0000);
      check_eq("mrst_ar", ar_out, 16'h0000);
      check_eq("mrst_dr", dr_out, 16'h0000);
      check_eq("mrst_ir", ir_out, 16'h0000);
      check_eq("mrst_r5", r5_out, 16'h0000);
      check_eq("mrst_z", {15'd0, Z}, 16'h0000);
      check_eq("mrst_err", {15'd0, bus_err}, 16'h0000);
      #1 rst_n = 1'b1;
      RAC = 1'b0; WR1 = 1'b0;
      tick();
      check_eq("post_rst_pc", pc_out, 16'h0001);
      check_eq("post_rst_err", {15'd0, bus_err}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/register_bank.md
# register_bank

Datapath register bank and shared bus for one processor core, directly downstream of the microprogrammed control unit. It holds the architectural registers AR, DR, PC, IR, R1–R7 and AC and executes the per-cycle read, write, increment and reset strobes the control unit issues. It drives a single shared bus, and returns IR and the registered zero flag Z to the control unit, closing the fetch/decode loop.

## Interface
- DATA_W, 16, width of every register, the bus and all data ports

- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- RAR, RDR, RPC, RIR, RR1..RR7, RAC  in  1 each  bus source selects (one-hot intended)
- WAR, WDR, WPC, WIR, WR1..WR7, WAC  in  1 each  load register from bus at next edge
- RSTR1..RSTR7  in  1 each  synchronous clear of R1..R7
- R2INC  in  1  R2 <= R2+1
- PCINC  in  1  PC <= PC+1
- ALUOP  in  1  AC <= alu_result; Z <= (alu_result==0)
- INSREAD  in  1  IR <= imem_rdata
- MEMREAD  in  1  DR <= dmem_rdata
- alu_result  in  DATA_W  ALU output
- imem_rdata  in  DATA_W  instruction memory read data
- dmem_rdata  in  DATA_W  data memory read data
- bus  out  DATA_W  shared bus value (combinational)
- pc_out, ar_out, dr_out, ir_out, ac_out, r1_out, r5_out  out  DATA_W  direct register taps (imem address, dmem address, dmem write data, control unit IR, ALU operands)
- Z  out  1  registered zero flag to control unit
- bus_err  out  1  sticky bus-contention flag

## Operation
- Bus: bitwise OR of every register whose R-select is high; 0 when none selected. Purely combinational from register state and selects.
- Each register independently resolves its strobes at each rising edge. Priority is highest first:
  - R1, R3–R7: RSTRx > Wx > hold.
  - R2: RSTR2 > WR2 > R2INC > hold.
  - PC: WPC > PCINC > hold.
  - IR: INSREAD > WIR > hold.
  - DR: MEMREAD > WDR > hold.
  - AC: ALUOP > WAC > hold.
  - AR: WAR > hold.
- Read and write of the same register in the same cycle is legal. The bus carries the old value, so the register reloads itself: no change.
- Increments are modulo 2^DATA_W: 0xFFFF+1 -> 0x0000, no carry out.
- Z changes only on ALUOP cycles and holds otherwise. WAC does not affect Z.
- bus_err: set at an edge where two or more R-selects are high. It stays set until rst_n is asserted. The bus still shows the OR in that cycle.

## Timing
- Reset (rst_n=0, asynchronous): every register = 0, Z=0, bus_err=0. All taps therefore read 0, and bus reads 0 until a select is asserted.
- Reset asserted mid-cycle overrides any pending strobe. The first edge after release behaves normally.
- Write latency: 1 cycle. A value on the bus in cycle n is visible on the register tap in cycle n+1.
- Taps are register outputs with no combinational path from strobes. bus is the only combinational output.
- Memory data (imem_rdata, dmem_rdata) must be valid in the strobe cycle. It is sampled at that edge, with no handshake.
- Z is valid the cycle after ALUOP, for the control unit's branch decision at the next microinstruction.

## Test plan
- Reset: drive all registers non-zero, pulse rst_n low between edges -> all taps, Z and bus_err read 0 immediately, before the next clk.
- Transfer: load R1=0x1234, then RR1+WR4 for one cycle -> bus=0x1234 in that cycle, R4=0x1234 next cycle, bus_err=0.
- Priority/wrap: PC=0xFFFF with PCINC -> PC=0x0000. R2=0x0007 with WR2 (bus=0x00A0)+R2INC -> R2=0x00A0. Same cycle with RSTR2 added -> R2=0x0000.
- ALU/Z: ALUOP with alu_result=0x0000 -> AC=0, Z=1. Then WAC with bus=0x0005 -> AC=5, Z stays 1. Then ALUOP with alu_result=0x0003 -> Z=0.
- Fetch: PC=0x0010, imem_rdata=0xA512, INSREAD+PCINC -> IR=0xA512 and PC=0x0011 next cycle. INSREAD+WIR together -> IR=imem_rdata.
- Contention: R3=0x00F0, AC=0x0F00, RR3+RAC -> bus=0x0FF0, bus_err=1 from the next cycle and still 1 after selects drop, until rst_n.
